// File: rtl/led_pattern_gen_pkg.sv
// ---------------------------------------------------------------------------
// led_pattern_pkg
// Shared constants for the LED pattern engine: pattern mode codes as written
// by the CPU into the LED mode register, and the direction encoding used by
// the ping-pong and breathe state machines.
// No ports (package).
// ---------------------------------------------------------------------------
package led_pattern_pkg;

    localparam int MODE_W = 3;

    localparam logic [MODE_W-1:0] MODE_OFF      = 3'd0;
    localparam logic [MODE_W-1:0] MODE_LEFT     = 3'd1;
    localparam logic [MODE_W-1:0] MODE_RIGHT    = 3'd2;
    localparam logic [MODE_W-1:0] MODE_FLASH    = 3'd3;
    localparam logic [MODE_W-1:0] MODE_PINGPONG = 3'd4;
    localparam logic [MODE_W-1:0] MODE_FILL     = 3'd5;
    localparam logic [MODE_W-1:0] MODE_BREATHE  = 3'd6;

    // Direction bit shared by ping-pong (toward MSB/LSB) and breathe (brighter/dimmer)
    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/led_pattern_gen_prescaler.sv
// ---------------------------------------------------------------------------
// led_prescaler
// Programmable step-rate divider. Counts enabled cycles and raises tick when
// the count has reached speed, giving one tick every speed+1 enabled cycles.
// The compare is ">=" so a speed lowered below the running count ticks on the
// very next enabled cycle instead of wrapping through 2^CNT_W.
// Ports:
//   clk    in   1      system clock
//   RST    in   1      asynchronous active-high reset
//   enable in   1      count only while high; frozen otherwise
//   clear  in   1      restart count at 0 and suppress tick this cycle
//   speed  in   CNT_W  step period minus one
//   tick   out  1      combinational step strobe (registered by the top)
// ---------------------------------------------------------------------------
module led_prescaler
    import led_pattern_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             RST,
    input  logic             enable,
    input  logic             clear,
    input  logic [CNT_W-1:0] speed,
    output logic             tick
);

    logic [CNT_W-1:0] cnt_r;
    logic             at_limit_s;

    assign at_limit_s = (cnt_r >= speed);
    assign tick       = enable & ~clear & at_limit_s;

    // Step counter: clear has priority, then count or restart while enabled
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (clear) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (enable) begin
            if (at_limit_s) begin
                cnt_r <= {CNT_W{1'b0}};
            end else begin
                cnt_r <= cnt_r + CNT_W'(1'b1);
            end
        end else begin
            cnt_r <= cnt_r;
        end
    end

endmodule

// File: rtl/led_pattern_gen.sv
// ---------------------------------------------------------------------------
// led_pattern_gen
// Multi-LED pattern engine: shift left/right, flash, ping-pong, bar-fill and
// PWM breathe, advanced by a programmable prescaler tick. A change of mode
// restarts the prescaler and reloads the pattern's initial value; a tick in
// the same cycle as a mode change is discarded.
// LED is registered from the next-state decode, so it always shows the
// pattern held in the state registers and changes in the same cycle as
// step_pulse.
// Ports:
//   clk        in   1        system clock
//   RST        in   1        asynchronous active-high reset
//   enable     in   1        run when high; freeze prescaler/pattern/PWM when low
//   mode       in   3        pattern select (see led_pattern_pkg)
//   speed      in   CNT_W    step period = speed+1 cycles
//   LED        out  NUM_LED  registered pattern, bit0 = LED0
//   LEDclk     out  1        registered, toggles on every step tick
//   step_pulse out  1        registered one-cycle strobe per step tick
// ---------------------------------------------------------------------------
module led_pattern_gen
    import led_pattern_pkg::*;
#(
    parameter int NUM_LED = 8,
    parameter int CNT_W   = 32,
    parameter int PWM_W   = 8
) (
    input  logic               clk,
    input  logic               RST,
    input  logic               enable,
    input  logic [MODE_W-1:0]  mode,
    input  logic [CNT_W-1:0]   speed,
    output logic [NUM_LED-1:0] LED,
    output logic               LEDclk,
    output logic               step_pulse
);

    localparam logic [NUM_LED-1:0] LED_ZERO  = {NUM_LED{1'b0}};
    localparam logic [NUM_LED-1:0] LED_ONES  = {NUM_LED{1'b1}};
    localparam logic [NUM_LED-1:0] ONE_LSB   = NUM_LED'(1'b1);
    localparam logic [NUM_LED-1:0] ONE_MSB   = ONE_LSB << (NUM_LED - 1);
    localparam logic [PWM_W-1:0]   LVL_ZERO  = {PWM_W{1'b0}};
    localparam logic [PWM_W-1:0]   LVL_ONE   = PWM_W'(1'b1);
    localparam logic [PWM_W-1:0]   LVL_MAX   = {PWM_W{1'b1}};
    localparam logic [PWM_W-1:0]   LVL_TOPM1 = LVL_MAX - LVL_ONE;

    logic [MODE_W-1:0]  mode_q_r;
    logic [NUM_LED-1:0] pattern_r,    pattern_nx_s;
    logic               dir_r,        dir_nx_s;
    logic [PWM_W-1:0]   level_r,      level_nx_s;
    logic               lvl_dir_r,    lvl_dir_nx_s;
    logic [PWM_W-1:0]   pwm_r,        pwm_nx_s;
    logic [NUM_LED-1:0] led_nx_s;
    logic               change_s;
    logic               tick_s;

    assign change_s = (mode != mode_q_r);

    led_prescaler #(
        .CNT_W (CNT_W)
    ) u_prescaler (
        .clk    (clk),
        .RST    (RST),
        .enable (enable),
        .clear  (change_s),
        .speed  (speed),
        .tick   (tick_s)
    );

    // State register: mode latch, pattern, directions, breathe level and PWM counter
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            mode_q_r  <= MODE_OFF;
            pattern_r <= LED_ZERO;
            dir_r     <= DIR_UP;
            level_r   <= LVL_ZERO;
            lvl_dir_r <= DIR_UP;
            pwm_r     <= {PWM_W{1'b0}};
        end else begin
            mode_q_r  <= mode;
            pattern_r <= pattern_nx_s;
            dir_r     <= dir_nx_s;
            level_r   <= level_nx_s;
            lvl_dir_r <= lvl_dir_nx_s;
            pwm_r     <= pwm_nx_s;
        end
    end

    // Next-state: reload on mode change, otherwise advance the active pattern on tick
    always_comb begin
        pattern_nx_s = pattern_r;
        dir_nx_s     = dir_r;
        level_nx_s   = level_r;
        lvl_dir_nx_s = lvl_dir_r;

        // PWM counter free-runs whenever the engine is enabled
        if (enable) begin
            pwm_nx_s = pwm_r + LVL_ONE;
        end else begin
            pwm_nx_s = pwm_r;
        end

        if (change_s) begin
            // Init values are selected by the incoming mode, which is the next mode_q
            dir_nx_s     = DIR_UP;
            level_nx_s   = LVL_ZERO;
            lvl_dir_nx_s = DIR_UP;
            case (mode)
                MODE_LEFT:     pattern_nx_s = ONE_LSB;
                MODE_RIGHT:    pattern_nx_s = ONE_MSB;
                MODE_FLASH:    pattern_nx_s = LED_ONES;
                MODE_PINGPONG: pattern_nx_s = ONE_LSB;
                default:       pattern_nx_s = LED_ZERO;
            endcase
        end else if (tick_s) begin
            case (mode_q_r)
                // Shift-or rotates also degenerate to "hold" for a single LED
                MODE_LEFT: begin
                    pattern_nx_s = (pattern_r << 1) | (pattern_r >> (NUM_LED - 1));
                end
                MODE_RIGHT: begin
                    pattern_nx_s = (pattern_r >> 1) | (pattern_r << (NUM_LED - 1));
                end
                MODE_FLASH: begin
                    pattern_nx_s = ~pattern_r;
                end
                MODE_PINGPONG: begin
                    // Reverse when standing on an end LED so the end is not shown twice
                    if (NUM_LED == 1) begin
                        pattern_nx_s = pattern_r;
                    end else if (dir_r == DIR_UP) begin
                        if (pattern_r[NUM_LED-1]) begin
                            pattern_nx_s = pattern_r >> 1;
                            dir_nx_s     = DIR_DOWN;
                        end else begin
                            pattern_nx_s = pattern_r << 1;
                        end
                    end else begin
                        if (pattern_r[0]) begin
                            pattern_nx_s = pattern_r << 1;
                            dir_nx_s     = DIR_UP;
                        end else begin
                            pattern_nx_s = pattern_r >> 1;
                        end
                    end
                end
                MODE_FILL: begin
                    // A full bar empties on the next step
                    if (&pattern_r) begin
                        pattern_nx_s = LED_ZERO;
                    end else begin
                        pattern_nx_s = (pattern_r << 1) | ONE_LSB;
                    end
                end
                MODE_BREATHE: begin
                    // Turn around on arriving at an end so neither end level dwells
                    if (lvl_dir_r == DIR_UP) begin
                        level_nx_s = level_r + LVL_ONE;
                        if (level_r == LVL_TOPM1) begin
                            lvl_dir_nx_s = DIR_DOWN;
                        end else begin
                            lvl_dir_nx_s = DIR_UP;
                        end
                    end else begin
                        level_nx_s = level_r - LVL_ONE;
                        if (level_r == LVL_ONE) begin
                            lvl_dir_nx_s = DIR_UP;
                        end else begin
                            lvl_dir_nx_s = DIR_DOWN;
                        end
                    end
                end
                default: begin
                    pattern_nx_s = LED_ZERO;
                end
            endcase
        end else begin
            pattern_nx_s = pattern_r;
        end
    end

    // Output decode from next state (mode is the next value of mode_q)
    always_comb begin
        led_nx_s = LED_ZERO;
        case (mode)
            MODE_LEFT, MODE_RIGHT, MODE_FLASH, MODE_PINGPONG, MODE_FILL: begin
                led_nx_s = pattern_nx_s;
            end
            MODE_BREATHE: begin
                led_nx_s = {NUM_LED{(pwm_nx_s < level_nx_s)}};
            end
            default: begin
                led_nx_s = LED_ZERO;
            end
        endcase
    end

    // Output register: LED, visible step clock and step strobe
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            LED        <= LED_ZERO;
            LEDclk     <= 1'b0;
            step_pulse <= 1'b0;
        end else begin
            LED        <= led_nx_s;
            LEDclk     <= LEDclk ^ tick_s;
            step_pulse <= tick_s;
        end
    end

endmodule
